// File: rtl/pipelined_datapath_if.sv
// Instruction-in / result-out bundle for pipelined_datapath, plus the debug read port.
// The datapath side uses the slave modport, the instruction source uses master.
interface pipelined_datapath_if #(
    parameter int WIDTH = 16,
    parameter int RB    = 4
);
    logic             InValid;
    logic             InReady;
    logic [3:0]       Op;
    logic [RB-1:0]    Dst;
    logic [RB-1:0]    Src;
    logic [WIDTH-1:0] Imm;
    logic             ImmSel;
    logic             OutValid;
    logic [WIDTH-1:0] AluBus;
    logic [4:0]       Flags;
    logic [RB-1:0]    RdAddr;
    logic [WIDTH-1:0] RdData;

    // An instruction transfers on a rising edge where InValid && InReady; OutValid is a
    // one-cycle pulse with no back-pressure, AluBus/Flags hold until the next result.
    modport slave (
        input  InValid, Op, Dst, Src, Imm, ImmSel, RdAddr,
        output InReady, OutValid, AluBus, Flags, RdData
    );

    modport master (
        output InValid, Op, Dst, Src, Imm, ImmSel, RdAddr,
        input  InReady, OutValid, AluBus, Flags, RdData
    );
endinterface

// File: rtl/pipelined_datapath.sv
// Two-stage register-file ALU: S1 latches operands, S2 executes/writes back/flags.
// Define DATAPATH_FWD_EN to forward S2 results into S1 operands instead of stalling.
module pipelined_datapath #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    pipelined_datapath_if.slave  bus
);
    localparam int RB = $clog2(NREGS);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_LSH  = 4'd8;

    function automatic logic op_writes(input logic [3:0] op);
        return (op <= OP_LSH) && (op != OP_CMP);
    endfunction

    logic [WIDTH-1:0] regs_q [NREGS];

    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic [RB-1:0]    s1_dst_q, s1_dst_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_bus_q, alu_bus_d;
    logic [4:0]       flags_q, flags_d;

    logic [WIDTH-1:0] alu_res;
    logic [4:0]       alu_flags;
    logic [WIDTH:0]   sum_w;
    logic             fl_n, fl_z, fl_f, fl_l, fl_c;

    // S2 execute; flags not touched by an op keep their previous value.
    always_comb begin
        alu_res = '0;
        sum_w   = '0;
        fl_n    = flags_q[4];
        fl_z    = flags_q[3];
        fl_f    = flags_q[2];
        fl_l    = flags_q[1];
        fl_c    = flags_q[0];
        case (s1_op_q)
            OP_ADD, OP_ADDC: begin
                sum_w   = {1'b0, s1_a_q} + {1'b0, s1_b_q}
                        + {{WIDTH{1'b0}}, (s1_op_q == OP_ADDC) & flags_q[0]};
                alu_res = sum_w[WIDTH-1:0];
                fl_c    = sum_w[WIDTH];
                fl_f    = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1])
                        && (alu_res[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = s1_a_q - s1_b_q;
                fl_c    = s1_a_q < s1_b_q;
                fl_f    = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1])
                        && (alu_res[WIDTH-1] != s1_a_q[WIDTH-1]);
                fl_l    = $signed(s1_a_q) < $signed(s1_b_q);
            end
            OP_AND:  alu_res = s1_a_q & s1_b_q;
            OP_OR:   alu_res = s1_a_q | s1_b_q;
            OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
            OP_MOV:  alu_res = s1_b_q;
            OP_LSH:  alu_res = s1_b_q[WIDTH-1] ? (s1_a_q >> 1) : (s1_a_q << 1);
            default: alu_res = '0;
        endcase
        if (s1_op_q <= OP_LSH) begin
            fl_z = (alu_res == '0);
            fl_n = alu_res[WIDTH-1];
        end
        alu_flags = {fl_n, fl_z, fl_f, fl_l, fl_c};
    end

    logic             s1_writes, haz_a, haz_b, stall, in_ready, accept, wb_en;
    logic [WIDTH-1:0] op_a, op_b;

    assign s1_writes = s1_valid_q && op_writes(s1_op_q);
    assign haz_a     = s1_writes && (s1_dst_q == bus.Dst);
    assign haz_b     = s1_writes && !bus.ImmSel && (s1_dst_q == bus.Src);
    assign wb_en     = s1_writes;

`ifdef DATAPATH_FWD_EN
    assign stall = 1'b0;
    assign op_a  = haz_a ? alu_res : regs_q[bus.Dst];
    assign op_b  = bus.ImmSel ? bus.Imm : (haz_b ? alu_res : regs_q[bus.Src]);
`else
    // Hold off one cycle so the operand read sees the writeback of the S1 instruction.
    assign stall = haz_a || haz_b;
    assign op_a  = regs_q[bus.Dst];
    assign op_b  = bus.ImmSel ? bus.Imm : regs_q[bus.Src];
`endif

    assign in_ready = !Reset && !stall;
    assign accept   = bus.InValid && in_ready;

    always_comb begin
        s1_valid_d  = accept;
        s1_op_d     = s1_op_q;
        s1_dst_d    = s1_dst_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        if (accept) begin
            s1_op_d  = bus.Op;
            s1_dst_d = bus.Dst;
            s1_a_d   = op_a;
            s1_b_d   = op_b;
        end
        out_valid_d = s1_valid_q;
        alu_bus_d   = s1_valid_q ? alu_res : alu_bus_q;
        flags_d     = s1_valid_q ? alu_flags : flags_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_dst_q    <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            out_valid_q <= 1'b0;
            alu_bus_q   <= '0;
            flags_q     <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_dst_q    <= s1_dst_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            out_valid_q <= out_valid_d;
            alu_bus_q   <= alu_bus_d;
            flags_q     <= flags_d;
            if (wb_en) begin
                regs_q[s1_dst_q] <= alu_res;
            end
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = out_valid_q;
    assign bus.AluBus   = alu_bus_q;
    assign bus.Flags    = flags_q;
    assign bus.RdData   = regs_q[bus.RdAddr];
endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed bench for pipelined_datapath: a 16-bit/16-reg instance and an 8-bit/8-reg instance.
// Expected InReady timing follows DATAPATH_FWD_EN; results and flags are config-independent.
module tb_pipelined_datapath;
    logic Clk;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

`ifdef DATAPATH_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    pipelined_datapath_if #(.WIDTH(16), .RB(4)) bus16 ();
    pipelined_datapath_if #(.WIDTH(8),  .RB(3)) bus8 ();

    pipelined_datapath #(.WIDTH(16), .NREGS(16)) dut16 (.Clk(Clk), .Reset(Reset), .bus(bus16.slave));
    pipelined_datapath #(.WIDTH(8),  .NREGS(8))  dut8  (.Clk(Clk), .Reset(Reset), .bus(bus8.slave));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Presents one instruction and returns at the falling edge after it is accepted.
    task automatic issue(input logic [3:0] op, input logic [3:0] dst, input logic [3:0] src,
                         input logic [15:0] imm, input logic sel, output logic first_ready);
        bus16.InValid = 1'b1;
        bus16.Op      = op;
        bus16.Dst     = dst;
        bus16.Src     = src;
        bus16.Imm     = imm;
        bus16.ImmSel  = sel;
        #1;
        first_ready = bus16.InReady;
        for (int n = 0; n < 8 && !bus16.InReady; n++) begin
            @(posedge Clk);
            @(negedge Clk);
            #1;
        end
        if (!bus16.InReady) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout InReady got 0 want 1");
        end
        @(posedge Clk);
        @(negedge Clk);
        bus16.InValid = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus16.InValid = 0; bus16.Op = 0; bus16.Dst = 0; bus16.Src = 0;
        bus16.Imm = 0; bus16.ImmSel = 0; bus16.RdAddr = 0;
        bus8.InValid = 0; bus8.Op = 0; bus8.Dst = 0; bus8.Src = 0;
        bus8.Imm = 0; bus8.ImmSel = 0; bus8.RdAddr = 0;
        repeat (3) @(negedge Clk);
        checks++;
        if (bus16.InReady !== 1'b0) begin
            errors++; $display("FAIL ready_in_reset got %b want 0", bus16.InReady);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (bus16.InReady !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset got %b want 1", bus16.InReady);
        end
        checks++;
        if ({bus16.OutValid, bus16.AluBus, bus16.Flags} !== 22'h0) begin
            errors++; $display("FAIL reset_outputs got ov=%b bus=%h fl=%b want 0", bus16.OutValid, bus16.AluBus, bus16.Flags);
        end
        bus16.RdAddr = 4'd15;
        #1;
        checks++;
        if (bus16.RdData !== 16'h0) begin
            errors++; $display("FAIL reset_r15 got %h want 0000", bus16.RdData);
        end
    endtask

    task automatic test_mov();
        logic r;
        issue(4'd7, 4'd1, 4'd0, 16'h1234, 1'b1, r);
        checks++;
        if (bus16.OutValid !== 1'b0) begin
            errors++; $display("FAIL mov_early_valid got %b want 0", bus16.OutValid);
        end
        step();
        checks++;
        if (bus16.OutValid !== 1'b1 || bus16.AluBus !== 16'h1234 || bus16.Flags !== 5'b00000) begin
            errors++; $display("FAIL mov_result got ov=%b bus=%h fl=%b want 1 1234 00000", bus16.OutValid, bus16.AluBus, bus16.Flags);
        end
        bus16.RdAddr = 4'd1;
        #1;
        checks++;
        if (bus16.RdData !== 16'h1234) begin
            errors++; $display("FAIL mov_rd got %h want 1234", bus16.RdData);
        end
        step();
        checks++;
        if (bus16.OutValid !== 1'b0) begin
            errors++; $display("FAIL mov_pulse got %b want 0", bus16.OutValid);
        end
    endtask

    task automatic test_add_carry();
        logic r;
        issue(4'd7, 4'd2, 4'd0, 16'h0001, 1'b1, r);
        step();
        issue(4'd0, 4'd2, 4'd0, 16'hFFFF, 1'b1, r);
        step();
        checks++;
        if (bus16.AluBus !== 16'h0000 || bus16.Flags !== 5'b01001) begin
            errors++; $display("FAIL add_wrap got bus=%h fl=%b want 0000 01001", bus16.AluBus, bus16.Flags);
        end
        issue(4'd1, 4'd2, 4'd0, 16'h0000, 1'b1, r);
        step();
        checks++;
        if (bus16.AluBus !== 16'h0001 || bus16.Flags !== 5'b00000) begin
            errors++; $display("FAIL addc got bus=%h fl=%b want 0001 00000", bus16.AluBus, bus16.Flags);
        end
        bus16.RdAddr = 4'd2;
        #1;
        checks++;
        if (bus16.RdData !== 16'h0001) begin
            errors++; $display("FAIL addc_rd got %h want 0001", bus16.RdData);
        end
    endtask

    task automatic test_raw_hazard();
        logic r;
        logic exp_ov;
        issue(4'd7, 4'd3, 4'd0, 16'h0005, 1'b1, r);
        issue(4'd0, 4'd3, 4'd3, 16'h0000, 1'b0, r);
        checks++;
        if (r !== FWD) begin
            errors++; $display("FAIL raw_ready got %b want %b", r, FWD);
        end
        // With forwarding the MOV result is still on the bus here; after a stall it has passed.
        exp_ov = FWD;
        checks++;
        if (bus16.OutValid !== exp_ov) begin
            errors++; $display("FAIL raw_mov_valid got %b want %b", bus16.OutValid, exp_ov);
        end
        step();
        checks++;
        if (bus16.OutValid !== 1'b1 || bus16.AluBus !== 16'h000A) begin
            errors++; $display("FAIL raw_add got ov=%b bus=%h want 1 000a", bus16.OutValid, bus16.AluBus);
        end
        bus16.RdAddr = 4'd3;
        #1;
        checks++;
        if (bus16.RdData !== 16'h000A) begin
            errors++; $display("FAIL raw_rd got %h want 000a", bus16.RdData);
        end
        // Src matches the S1 destination but the immediate is selected: no hazard.
        issue(4'd7, 4'd10, 4'd0, 16'h0100, 1'b1, r);
        issue(4'd0, 4'd11, 4'd10, 16'h0002, 1'b1, r);
        checks++;
        if (r !== 1'b1) begin
            errors++; $display("FAIL imm_no_hazard_ready got %b want 1", r);
        end
        step();
        checks++;
        if (bus16.AluBus !== 16'h0002 || bus16.Flags !== 5'b00000) begin
            errors++; $display("FAIL imm_no_hazard got bus=%h fl=%b want 0002 00000", bus16.AluBus, bus16.Flags);
        end
    endtask

    task automatic test_cmp();
        logic r;
        issue(4'd7, 4'd4, 4'd0, 16'h8000, 1'b1, r);
        step();
        issue(4'd3, 4'd4, 4'd0, 16'h0001, 1'b1, r);
        step();
        checks++;
        if (bus16.AluBus !== 16'h7FFF || bus16.Flags !== 5'b00110) begin
            errors++; $display("FAIL cmp got bus=%h fl=%b want 7fff 00110", bus16.AluBus, bus16.Flags);
        end
        bus16.RdAddr = 4'd4;
        #1;
        checks++;
        if (bus16.RdData !== 16'h8000) begin
            errors++; $display("FAIL cmp_nowrite got %h want 8000", bus16.RdData);
        end
    endtask

    task automatic test_logic_ops();
        logic [3:0]  ops  [9] = '{4'd7, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd12, 4'd2};
        logic [15:0] imms [9] = '{16'hF0F0, 16'hFF00, 16'h000F, 16'hF00F, 16'h4001,
                                  16'h0000, 16'h8000, 16'h1234, 16'h4002};
        logic [15:0] ebus [9] = '{16'hF0F0, 16'hF000, 16'hF00F, 16'h0000, 16'h4001,
                                  16'h8002, 16'h4001, 16'h0000, 16'hFFFF};
        logic [4:0]  efl  [9] = '{5'b10110, 5'b10110, 5'b10110, 5'b01110, 5'b00110,
                                  5'b10110, 5'b00110, 5'b00110, 5'b10011};
        logic r;
        for (int i = 0; i < 9; i++) begin
            issue(ops[i], 4'd9, 4'd0, imms[i], 1'b1, r);
            step();
            checks++;
            if (bus16.OutValid !== 1'b1 || bus16.AluBus !== ebus[i] || bus16.Flags !== efl[i]) begin
                errors++;
                $display("FAIL logic_%0d got ov=%b bus=%h fl=%b want 1 %h %b", i, bus16.OutValid, bus16.AluBus, bus16.Flags, ebus[i], efl[i]);
            end
            if (ops[i] == 4'd12) begin
                bus16.RdAddr = 4'd9;
                #1;
                checks++;
                if (bus16.RdData !== 16'h4001) begin
                    errors++; $display("FAIL nop_nowrite got %h want 4001", bus16.RdData);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic r;
        issue(4'd7, 4'd6, 4'd0, 16'hFFFF, 1'b1, r);
        step();
        issue(4'd0, 4'd7, 4'd0, 16'h0000, 1'b1, r);
        step();
        checks++;
        if (bus16.Flags !== 5'b01010) begin
            errors++; $display("FAIL b2b_clear_c got fl=%b want 01010", bus16.Flags);
        end
        issue(4'd0, 4'd6, 4'd0, 16'h0001, 1'b1, r);
        issue(4'd1, 4'd7, 4'd0, 16'h0000, 1'b1, r);
        checks++;
        if (r !== 1'b1) begin
            errors++; $display("FAIL b2b_ready got %b want 1", r);
        end
        checks++;
        if (bus16.OutValid !== 1'b1 || bus16.AluBus !== 16'h0000 || bus16.Flags !== 5'b01011) begin
            errors++; $display("FAIL b2b_add got ov=%b bus=%h fl=%b want 1 0000 01011", bus16.OutValid, bus16.AluBus, bus16.Flags);
        end
        step();
        checks++;
        if (bus16.OutValid !== 1'b1 || bus16.AluBus !== 16'h0001 || bus16.Flags !== 5'b00010) begin
            errors++; $display("FAIL b2b_addc got ov=%b bus=%h fl=%b want 1 0001 00010", bus16.OutValid, bus16.AluBus, bus16.Flags);
        end
    endtask

    task automatic test_reset_inflight();
        logic r;
        issue(4'd0, 4'd5, 4'd0, 16'h0007, 1'b1, r);
        Reset = 1'b1;
        step();
        bus16.RdAddr = 4'd5;
        #1;
        checks++;
        if ({bus16.OutValid, bus16.AluBus, bus16.Flags, bus16.RdData, bus16.InReady} !== 39'h0) begin
            errors++;
            $display("FAIL inflight_reset got ov=%b bus=%h fl=%b r5=%h rdy=%b want all 0", bus16.OutValid, bus16.AluBus, bus16.Flags, bus16.RdData, bus16.InReady);
        end
        Reset = 1'b0;
        step();
        checks++;
        if (bus16.OutValid !== 1'b0 || bus16.RdData !== 16'h0000) begin
            errors++; $display("FAIL inflight_discard got ov=%b r5=%h want 0 0000", bus16.OutValid, bus16.RdData);
        end
    endtask

    task automatic test_width8();
        bus8.InValid = 1'b1;
        bus8.Op      = 4'd2;
        bus8.Dst     = 3'd0;
        bus8.Src     = 3'd0;
        bus8.Imm     = 8'h01;
        bus8.ImmSel  = 1'b1;
        #1;
        checks++;
        if (bus8.InReady !== 1'b1) begin
            errors++; $display("FAIL w8_ready got %b want 1", bus8.InReady);
        end
        step();
        bus8.InValid = 1'b0;
        step();
        checks++;
        if (bus8.OutValid !== 1'b1 || bus8.AluBus !== 8'hFF || bus8.Flags !== 5'b10011) begin
            errors++; $display("FAIL w8_sub got ov=%b bus=%h fl=%b want 1 ff 10011", bus8.OutValid, bus8.AluBus, bus8.Flags);
        end
        bus8.RdAddr = 3'd0;
        #1;
        checks++;
        if (bus8.RdData !== 8'hFF) begin
            errors++; $display("FAIL w8_rd got %h want ff", bus8.RdData);
        end
    endtask

    initial begin
        test_reset();
        test_mov();
        test_add_carry();
        test_raw_hazard();
        test_cmp();
        test_logic_ops();
        test_back_to_back();
        test_reset_inflight();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
